// File: rtl/inv_sqrt_dispatch.sv
// ---------------------------------------------------------------------------
// inv_sqrt_dispatch
//
// Request/response front end for the 16-bit fast inverse square root core.
// Half-precision operands are buffered in a small FIFO and issued one at a
// time. Each job starts with a one-cycle reset pulse to the core, and the
// operand is held stable until the job ends. The core result and its
// overflow/underflow flags are captured, exceptions are mapped to IEEE half
// encodings, and the result is held on a valid/ready output.
//
// Parameters
//   DEPTH    input FIFO entries (power of two, >= 2)
//   TIMEOUT  maximum cycles spent waiting on the core (>= 16)
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   in_valid     upstream operand valid
//   in_ready     FIFO can accept (registered, equals !full)
//   in_data      half-precision operand
//   out_valid    result held for downstream
//   out_ready    downstream accepts
//   out_data     half-precision result
//   out_ofuf     10 = overflow, 01 = underflow, 00 = none
//   out_timeout  core did not finish within TIMEOUT cycles
//   core_x       operand to the core, registered and held
//   core_reset   start/clear pulse to the core
//   core_done    core completion flag
//   core_result  core result
//   core_ofuf    core flags
// ---------------------------------------------------------------------------
module inv_sqrt_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_ofuf,
    output logic        out_timeout,
    output logic [15:0] core_x,
    output logic        core_reset,
    input  logic        core_done,
    input  logic [15:0] core_result,
    input  logic [1:0]  core_ofuf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
    // Last WAIT cycle: the counter reaches TIMEOUT on this cycle's increment.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [15:0] HALF_QNAN    = 16'h7E00;
    localparam logic [15:0] HALF_POS_INF = 16'h7C00;
    localparam logic [15:0] HALF_ZERO    = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Map the core's flags onto the half-precision value handed downstream.
    function automatic logic [15:0] map_core_result(input logic [15:0] result,
                                                    input logic [1:0]  ofuf);
        logic [15:0] mapped;
        case (ofuf)
            2'b10:   mapped = HALF_POS_INF;
            2'b01:   mapped = HALF_ZERO;
            2'b00:   mapped = result;
            default: mapped = HALF_QNAN;  // both flags set is not a legal core report
        endcase
        return mapped;
    endfunction

    // FIFO storage and bookkeeping
    logic [15:0]      fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             in_ready_r;
    logic             push_s;
    logic             pop_s;
    logic [15:0]      head_s;

    // FSM and job control
    state_t           state_r;
    state_t           state_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_s;
    logic             tmo_last_s;

    // Output registers and their next values
    logic [15:0] core_x_r;
    logic [15:0] core_x_s;
    logic        core_reset_r;
    logic        core_reset_s;
    logic        out_valid_r;
    logic        out_valid_s;
    logic [15:0] out_data_r;
    logic [15:0] out_data_s;
    logic [1:0]  out_ofuf_r;
    logic [1:0]  out_ofuf_s;
    logic        out_timeout_r;
    logic        out_timeout_s;

    assign push_s     = in_valid && in_ready_r;
    assign pop_s      = (state_r == ST_IDLE) && (count_r != '0);
    assign head_s     = fifo_mem_r[rd_ptr_r];
    assign tmo_last_s = (tmo_cnt_r == TMO_LAST);

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers, count and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            in_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            // Built from the post-update count, so a pop frees a slot one
            // cycle later rather than combinationally.
            in_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    if (head_s[15]) begin
                        state_s = ST_HOLD;  // negative operands bypass the core
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (core_done || tmo_last_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and counter.
    always_comb begin
        core_x_s      = core_x_r;
        core_reset_s  = 1'b0;
        out_valid_s   = out_valid_r;
        out_data_s    = out_data_r;
        out_ofuf_s    = out_ofuf_r;
        out_timeout_s = out_timeout_r;
        tmo_cnt_s     = tmo_cnt_r;
        case (state_r)
            ST_IDLE: begin
                out_valid_s = 1'b0;
                if (pop_s) begin
                    if (head_s[15]) begin
                        out_valid_s   = 1'b1;
                        out_data_s    = HALF_QNAN;
                        out_ofuf_s    = 2'b00;
                        out_timeout_s = 1'b0;
                    end else begin
                        core_x_s     = head_s;
                        core_reset_s = 1'b1;  // high during START, clears stale done
                    end
                end else begin
                    core_reset_s = 1'b0;
                end
            end
            ST_START: begin
                tmo_cnt_s = '0;
            end
            ST_WAIT: begin
                tmo_cnt_s = tmo_cnt_r + TMO_ONE;
                if (core_done) begin
                    // A completion on the last allowed cycle still wins.
                    out_valid_s   = 1'b1;
                    out_data_s    = map_core_result(core_result, core_ofuf);
                    out_ofuf_s    = core_ofuf;
                    out_timeout_s = 1'b0;
                end else if (tmo_last_s) begin
                    out_valid_s   = 1'b1;
                    out_data_s    = HALF_QNAN;
                    out_ofuf_s    = 2'b00;
                    out_timeout_s = 1'b1;
                    core_reset_s  = 1'b1;  // abort the hung computation
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Output and job-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_x_r      <= 16'h0000;
            core_reset_r  <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= 16'h0000;
            out_ofuf_r    <= 2'b00;
            out_timeout_r <= 1'b0;
            tmo_cnt_r     <= '0;
        end else begin
            core_x_r      <= core_x_s;
            core_reset_r  <= core_reset_s;
            out_valid_r   <= out_valid_s;
            out_data_r    <= out_data_s;
            out_ofuf_r    <= out_ofuf_s;
            out_timeout_r <= out_timeout_s;
            tmo_cnt_r     <= tmo_cnt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_ofuf    = out_ofuf_r;
    assign out_timeout = out_timeout_r;
    assign core_x      = core_x_r;
    // The core is held cleared for every cycle reset is asserted, including
    // the first one before the registered pulse has been loaded.
    assign core_reset  = core_reset_r | reset;

endmodule

// File: tb/tb_inv_sqrt_dispatch.sv
module tb_inv_sqrt_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ofuf;
        logic        tmo;
        logic [3:0]  tol;
    } exp_t;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        in_valid    = 1'b0;
    logic [15:0] in_data     = 16'h0000;
    logic        out_ready   = 1'b0;
    logic        core_done   = 1'b0;
    logic [15:0] core_result = 16'h0000;
    logic [1:0]  core_ofuf   = 2'b00;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_ofuf;
    logic        out_timeout;
    logic [15:0] core_x;
    logic        core_reset;

    bit       stub_hang = 1'b0;
    logic [2:0] stub_cnt = 3'd0;
    int       errors = 0;
    int       checks = 0;
    exp_t     sb[$];

    inv_sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ofuf(out_ofuf), .out_timeout(out_timeout),
        .core_x(core_x), .core_reset(core_reset), .core_done(core_done),
        .core_result(core_result), .core_ofuf(core_ofuf)
    );

    always #5 clk = ~clk;

    // Core stub: {ofuf, result}. Flagged cases return junk data on purpose.
    function automatic logic [17:0] stub_core(input logic [15:0] x);
        case (x)
            16'h3C00: return {2'b00, 16'h3C00};
            16'h0000: return {2'b10, 16'h5555};
            16'h7C00: return {2'b01, 16'h1234};
            16'h4400: return {2'b00, 16'h3801};
            16'h5C00: return {2'b00, 16'h2BFF};
            default:  return {2'b00, x ^ 16'h0F0F};
        endcase
    endfunction

    // Core stub: 1.0 finishes on the first cycle after the clear, others after four.
    always @(posedge clk) begin
        if (core_reset) begin
            core_done   <= 1'b0;
            stub_cnt    <= 3'd0;
            core_result <= 16'h0000;
            core_ofuf   <= 2'b00;
        end else if (!core_done && !stub_hang) begin
            stub_cnt <= stub_cnt + 3'd1;
            if ((core_x == 16'h3C00 && stub_cnt == 3'd0) || stub_cnt == 3'd3) begin
                core_done <= 1'b1;
                {core_ofuf, core_result} <= stub_core(core_x);
            end
        end
    end

    function automatic exp_t expect_of(input logic [15:0] x, input bit tmo);
        exp_t e;
        e.tmo = 1'b0; e.tol = 4'd0; e.ofuf = 2'b00; e.data = 16'h0000;
        if (tmo) begin
            e.data = 16'h7E00; e.tmo = 1'b1;
        end else if (x[15]) begin
            e.data = 16'h7E00;
        end else begin
            case (x)
                16'h3C00: e.data = 16'h3C00;
                16'h0000: begin e.data = 16'h7C00; e.ofuf = 2'b10; end
                16'h7C00: begin e.data = 16'h0000; e.ofuf = 2'b01; end
                16'h4400: begin e.data = 16'h3800; e.tol = 4'd2; end
                16'h5C00: begin e.data = 16'h2C00; e.tol = 4'd2; end
                default:  e.data = x ^ 16'h0F0F;
            endcase
        end
        return e;
    endfunction

    task automatic push_op(input logic [15:0] x, input bit tmo);
        bit acc;
        int budget;
        acc = 1'b0; budget = 200;
        in_valid = 1'b1; in_data = x;
        while (!acc && budget > 0) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                sb.push_back(expect_of(x, tmo));
            end
            @(posedge clk); #1;
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin errors++; $display("FAIL push_accept: operand %h not accepted, want accepted", x); end
    endtask

    task automatic drain_sb(input int budget, output int first_cycle);
        exp_t e;
        int n;
        int d;
        n = 0; first_cycle = -1;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                e = sb.pop_front();
                if (first_cycle < 0) first_cycle = n;
                d = int'(out_data) - int'(e.data);
                checks++;
                if ($isunknown(out_data) || d > int'(e.tol) || d < -int'(e.tol)) begin
                    errors++; $display("FAIL result_data: got %h want %h (+-%0d)", out_data, e.data, e.tol);
                end
                checks++;
                if (out_ofuf !== e.ofuf) begin errors++; $display("FAIL result_ofuf: got %b want %b", out_ofuf, e.ofuf); end
                checks++;
                if (out_timeout !== e.tmo) begin errors++; $display("FAIL result_timeout: got %b want %b", out_timeout, e.tmo); end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d results missing, want 0", sb.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
        checks++; if (out_ofuf !== 2'b00 || out_timeout !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b/%b want 00/0", out_ofuf, out_timeout); end
        checks++; if (core_x !== 16'h0000) begin errors++; $display("FAIL rst_core_x: got %h want 0000", core_x); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_latency();
        logic ov [1:4];
        logic cr [1:4];
        logic [15:0] cx [1:4];
        int fc;
        out_ready = 1'b1;
        push_op(16'h3C00, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ov[k] = out_valid; cr[k] = core_reset; cx[k] = core_x;
        end
        checks++; if (cr[1] !== 1'b0 || cr[2] !== 1'b1 || cr[3] !== 1'b0) begin errors++; $display("FAIL start_pulse: got %b%b%b want 010", cr[1], cr[2], cr[3]); end
        checks++; if (cx[2] !== 16'h3C00 || cx[4] !== 16'h3C00) begin errors++; $display("FAIL core_x_hold: got %h/%h want 3c00", cx[2], cx[4]); end
        checks++; if (ov[4] !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0 at push+4", ov[4]); end
        drain_sb(50, fc);
        checks++; if (fc != 1) begin errors++; $display("FAIL latency: result %0d cycles after push+4, want 1", fc); end
    endtask

    task automatic test_exceptions();
        int fc;
        int pulses;
        out_ready = 1'b1;
        push_op(16'h0000, 1'b0);
        drain_sb(50, fc);
        push_op(16'h7C00, 1'b0);
        drain_sb(50, fc);
        out_ready = 1'b0;
        push_op(16'hC000, 1'b0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (core_reset === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL neg_core_reset: got %0d pulse cycles want 0", pulses); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL neg_hold_valid: got %b want 1", out_valid); end
        @(posedge clk); #1; out_ready = 1'b1;
        drain_sb(50, fc);
    endtask

    task automatic test_accuracy();
        int fc;
        out_ready = 1'b1;
        push_op(16'h4400, 1'b0);
        push_op(16'h5C00, 1'b0);
        drain_sb(100, fc);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops [6] = '{16'h3C00, 16'h4400, 16'hC000, 16'h0000, 16'h5C00, 16'h1234};
        exp_t e;
        int acc;
        int fc;
        out_ready = 1'b0; acc = 0;
        in_valid = 1'b1; in_data = ops[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && acc < 6) begin
                sb.push_back(expect_of(ops[acc], 1'b0));
                acc++;
            end
            @(posedge clk); #1;
            if (acc < 6) in_data = ops[acc];
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (acc != DEPTH + 1) begin errors++; $display("FAIL fill_accepted: got %0d want %0d", acc, DEPTH + 1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h3C00) begin errors++; $display("FAIL fill_hold: got %b/%h want 1/3c00", out_valid, out_data); end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            if (out_data !== e.data) begin errors++; $display("FAIL first_result: got %h want %h", out_data, e.data); end
        end else begin
            errors++; $display("FAIL first_result: got valid=%b want 1", out_valid);
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_pop_cycle: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b want 1", in_ready); end
        @(posedge clk); #1;
        drain_sb(300, fc);
    endtask

    task automatic test_timeout();
        int fc;
        int n;
        out_ready = 1'b0;
        stub_hang = 1'b1;
        push_op(16'h3C00, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (core_reset !== 1'b1 && n < 10);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL tmo_start: got core_reset %b want 1", core_reset); end
        repeat (TIMEOUT) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: got valid %b want 0 at START+%0d", out_valid, TIMEOUT); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_timeout !== 1'b1) begin errors++; $display("FAIL tmo_fire: got %b/%b want 1/1", out_valid, out_timeout); end
        checks++; if (out_data !== 16'h7E00) begin errors++; $display("FAIL tmo_data: got %h want 7e00", out_data); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL tmo_abort: got core_reset %b want 1", core_reset); end
        stub_hang = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        drain_sb(50, fc);
        push_op(16'h4400, 1'b0);
        drain_sb(100, fc);
    endtask

    task automatic test_reset_midop();
        int fc;
        int seen;
        out_ready = 1'b1;
        stub_hang = 1'b1;
        push_op(16'h3C00, 1'b0);
        push_op(16'h4400, 1'b0);
        push_op(16'h5C00, 1'b0);
        push_op(16'h0000, 1'b0);
        repeat (3) @(posedge clk);
        #1; reset = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset_early: got %b want 1", core_reset); end
        @(posedge clk); #1; reset = 1'b0; stub_hang = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got %b/%b want 0/0", in_ready, out_valid); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_flushed: got %0d valid cycles want 0", seen); end
        @(posedge clk); #1;
        push_op(16'h3C00, 1'b0);
        drain_sb(50, fc);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_extra: got %0d valid cycles want 0", seen); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_latency();
        test_exceptions();
        test_accuracy();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_sqrt_dispatch.md
Name: inv_sqrt_dispatch

Overview:
Request/response front end for the 16-bit fast inverse square root unit. It buffers half-precision operands in a small FIFO and issues them one at a time to the core. The core is started by pulsing its reset, and its operand must stay stable for the whole computation. The block captures the core's result and OFUF flags, maps exceptions to IEEE half encodings, and returns them through a valid/ready output.

Parameters:
DEPTH, 4, input FIFO entries; must be a power of two, at least 2
TIMEOUT, 255, maximum cycles in WAIT before the job is aborted; at least 16

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream operand valid
in_ready  output  1  FIFO can accept; equals !full
in_data  input  16  half-precision operand
out_valid  output  1  result held for downstream
out_ready  input  1  downstream accepts
out_data  output  16  half-precision result
out_ofuf  output  2  flags: 10 = overflow, 01 = underflow, 00 = none
out_timeout  output  1  core did not finish within TIMEOUT cycles
core_x  output  16  operand to the core; registered and held
core_reset  output  1  start/clear pulse to the core
core_done  input  1  core completion flag
core_result  input  16  core result
core_ofuf  input  2  core flags

Behaviour:
- Reset values: in_ready=0 during reset and 1 afterwards (FIFO empty). out_valid=0, out_data=0, out_ofuf=00, out_timeout=0, core_x=0, core_reset=1, state=IDLE, FIFO count=0, timeout counter=0.
- Reset mid-operation discards all FIFO contents and any in-flight or held result, with no output. core_reset stays high for the whole time reset is high.
- FIFO push occurs when in_valid && in_ready. in_ready depends only on count and is never raised by a same-cycle pop. FIFO order is preserved. The pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE: core_reset=0. If the FIFO is non-empty, pop the head entry.
  - If head[15]=1 (negative, including -0): skip the core. Load out_data=16'h7E00, out_ofuf=00, out_timeout=0. Go to HOLD.
  - Otherwise: load core_x=head, drive core_reset=1 for exactly one cycle, go to START.
- START: core_reset=0, timeout counter=0, go to WAIT.
- WAIT: core_x is held constant. The counter increments each cycle.
  - If core_done=1 on a given cycle, capture that same cycle. out_ofuf=core_ofuf. out_data is selected as follows:
    - core_ofuf=10: 16'h7C00
    - core_ofuf=01: 16'h0000
    - core_ofuf=00: core_result
  - Then go to HOLD.
  - If the counter reaches TIMEOUT without core_done: out_timeout=1, out_data=16'h7E00, out_ofuf=00, core_reset=1 for one cycle, go to HOLD.
- HOLD: out_valid=1 and the outputs are stable. When out_ready=1, drop out_valid on the next cycle and go to IDLE. The next issue happens no earlier than the following cycle.
- Only one job is in the core at a time. Results leave in input order.
- Minimum latency, from push cycle N to out_valid: IDLE pop at N+1, START at N+2, first WAIT at N+3. The core's 1.0 shortcut asserts done one cycle later, so out_valid is high at N+5.
- Pushes may continue during WAIT and HOLD until the FIFO is full.
- Stale core_done from a previous job is impossible, because the START-cycle pulse clears the core.

Test Plan:
- Push 16'h3C00 (1.0), out_ready=1 -> out_data=16'h3C00, out_ofuf=00, out_valid at push+5.
- Push 16'h0000 -> out_data=16'h7C00, out_ofuf=10, out_timeout=0. Push 16'hC000 (-2.0) -> out_data=16'h7E00, core_reset never pulses.
- Push 16'h4400 (4.0) -> out_data within ±2 ulp of 16'h3800 (0.5), out_ofuf=00. Push 16'h5C00 (256.0) -> within ±2 ulp of 16'h2C00 (0.0625).
- With out_ready=0, push continuously: DEPTH+1 operands are accepted (one already popped into the core), then in_ready=0. Release out_ready -> all results arrive in order, in_ready re-asserts one cycle after the first pop.
- Core stub with core_done tied to 0 -> out_timeout=1 and out_data=16'h7E00 exactly TIMEOUT+1 cycles after START; the following job completes normally.
- Assert reset for one cycle during WAIT with 3 entries queued -> out_valid stays 0 and count=0. The next push of 16'h3C00 returns 16'h3C00 only.
